// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants and saturating duty helpers for the LED PWM fader.
// Optional build macro: LED_PWM_GAMMA_EN (square-law duty curve in led_pwm_channel).
package led_pwm_pkg;

    localparam int CHANNELS_DEFAULT  = 8;
    localparam int PWM_BITS_DEFAULT  = 8;
    localparam int PRESCALE_DEFAULT  = 16;
    localparam int FADE_STEP_DEFAULT = 4;

    // Largest duty value for a PWM counter of the given width (full-on level).
    function automatic int duty_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    // Add one fade step, clamping at the full-on level instead of wrapping.
    function automatic int sat_inc(input int value, input int step, input int max_val);
        int sum;
        sum = value + step;
        return (sum > max_val) ? max_val : sum;
    endfunction

    // Remove one fade step, clamping at zero instead of wrapping.
    function automatic int sat_dec(input int value, input int step);
        int diff;
        diff = value - step;
        return (diff < 0) ? 0 : diff;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED's duty register, per-frame fade step and registered PWM compare.
// Optional build macro: LED_PWM_GAMMA_EN (duty_eff = duty*duty >> PWM_BITS).
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEFAULT,
    parameter int FADE_STEP = FADE_STEP_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                wrap,
    input  logic                target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(duty_max(PWM_BITS));

    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_next;
    logic [PWM_BITS-1:0] duty_eff;

`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;
    assign duty_sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
    assign duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty_eff = duty;
`endif

    // Move duty one step toward the target, only on the frame wrap tick.
    always_comb begin
        duty_next = duty;
        if (wrap) begin
            if (target) begin
                duty_next = PWM_BITS'(sat_inc(int'(duty), FADE_STEP, int'(MAX)));
            end else begin
                duty_next = PWM_BITS'(sat_dec(int'(duty), FADE_STEP));
            end
        end
    end

    // Duty register; holds its value between wraps and while disabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            duty <= '0;
        end else begin
            duty <= duty_next;
        end
    end

    // Registered compare; full duty forces the LED on so there is no dip at the wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led <= 1'b0;
        end else begin
            led <= enable & ((duty == MAX) | (pwm_cnt < duty_eff));
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: prescaled PWM frame counter driving CHANNELS fading LED outputs.
// Optional build macro: LED_PWM_GAMMA_EN (passed through to each led_pwm_channel).
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS  = CHANNELS_DEFAULT,
    parameter int PWM_BITS  = PWM_BITS_DEFAULT,
    parameter int PRESCALE  = PRESCALE_DEFAULT,
    parameter int FADE_STEP = FADE_STEP_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [CHANNELS-1:0] target,
    output logic [CHANNELS-1:0] leds,
    output logic                frame_strobe
);

    localparam int                  PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(duty_max(PWM_BITS));

    logic [PRE_W-1:0]    prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                wrap;

    assign tick = enable & (prescaler == PRE_LAST);
    assign wrap = tick & (pwm_cnt == CNT_LAST);

    // Prescaler divides clk down to PWM ticks; parked at zero while disabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescaler <= '0;
        end else if (!enable || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // PWM counter advances once per tick and wraps naturally at the frame end.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt <= '0;
        end else if (!enable) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Frame strobe is the registered wrap tick, one cycle wide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= wrap;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
        led_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_channel (
            .clk     (clk),
            .resetn  (resetn),
            .enable  (enable),
            .wrap    (wrap),
            .target  (target[ch]),
            .pwm_cnt (pwm_cnt),
            .led     (leds[ch])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed checks of reset, frame timing, fading, enable and mid-frame reset.
// Built with LED_PWM_GAMMA_EN undefined (linear duty).
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [7:0] target;
    logic [7:0] leds;
    logic       frame_strobe;

    int compared   = 0;
    int mismatched = 0;

    led_pwm_fader #(
        .CHANNELS  (8),
        .PWM_BITS  (4),
        .PRESCALE  (2),
        .FADE_STEP (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .target       (target),
        .leds         (leds),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rstVal, input logic enVal, input logic [7:0] tgtVal);
        resetn = rstVal;
        enable = enVal;
        target = tgtVal;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Count clock edges until the strobe shows up, and how many of them had leds[0] high.
    task automatic waitStrobe(output int edges, output int high0);
        edges = 0;
        high0 = 0;
        do begin
            @(negedge clk);
            edges++;
            if (leds[0] === 1'b1) high0++;
        end while (frame_strobe !== 1'b1 && edges < 200);
    endtask

    // Measure one full 32-cycle frame starting right after a strobe.
    task automatic checkFrame(input string tag, input int exp0, input int exp1);
        int high0;
        int high1;
        int strobeErr;
        high0 = 0;
        high1 = 0;
        strobeErr = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (leds[0] === 1'b1) high0++;
            if (leds[1] === 1'b1) high1++;
            if (frame_strobe !== (i == 31)) strobeErr++;
        end
        checkOutput({tag, " led0 high cycles"}, high0, exp0);
        checkOutput({tag, " led1 high cycles"}, high1, exp1);
        checkOutput({tag, " strobe pattern errors"}, strobeErr, 0);
    endtask

    initial begin
        int edges;
        int high0;
        int bad;

        applyStimulus(1'b0, 1'b1, 8'hFF);
        #1;
        checkOutput("reset leds", int'(leds), 0);
        checkOutput("reset strobe", int'(frame_strobe), 0);
        repeat (3) @(negedge clk);
        checkOutput("held reset leds", int'(leds), 0);
        checkOutput("held reset strobe", int'(frame_strobe), 0);

        applyStimulus(1'b1, 1'b1, 8'hFF);
        waitStrobe(edges, high0);
        checkOutput("first strobe latency", edges, 32);
        checkOutput("first frame led0 high", high0, 0);

        checkFrame("F1 duty4", 8, 8);
        applyStimulus(1'b1, 1'b1, 8'hFE);
        checkFrame("F2 duty8", 16, 16);
        checkFrame("F3 fade down", 8, 24);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        checkFrame("F4 duty0/15", 0, 32);
        checkFrame("F5 ramp up", 8, 32);

        repeat (10) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'hFF);
        @(negedge clk);
        checkOutput("disable leds", int'(leds), 0);
        checkOutput("disable strobe", int'(frame_strobe), 0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (leds !== 8'h00 || frame_strobe !== 1'b0) bad++;
        end
        checkOutput("disabled hold errors", bad, 0);

        applyStimulus(1'b1, 1'b1, 8'hFF);
        waitStrobe(edges, high0);
        checkOutput("re-enable strobe latency", edges, 32);
        checkOutput("re-enable frame led0 high", high0, 16);
        checkFrame("F7 duty12", 24, 32);
        checkFrame("F8 saturate", 32, 32);
        checkFrame("F9 full on across wrap", 32, 32);

        repeat (5) @(negedge clk);
        checkOutput("pre-reset leds", int'(leds), 'hFF);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async reset leds", int'(leds), 0);
        checkOutput("async reset strobe", int'(frame_strobe), 0);
        repeat (2) @(negedge clk);
        checkOutput("mid reset leds", int'(leds), 0);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        waitStrobe(edges, high0);
        checkOutput("post-reset strobe latency", edges, 32);
        checkOutput("post-reset frame led0 high", high0, 0);
        checkFrame("post-reset duty4", 8, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
